// File: rtl/pos_sched_pkg.sv
// ----------------------------------------------------------------------------
// pos_sched_pkg : shared FSM states and widths for position_tx_scheduler
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pos_sched_pkg;

    localparam int POS_W_DEFAULT = 10;
    localparam int TIMER_W       = 13;
    localparam int FCNT_W        = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        WAIT_ACK = 3'd2,
        XFER     = 3'd3,
        GAP      = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/position_tx_scheduler_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter : combinational one-hot round-robin grant with registered pointer
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic             found;
    int               cand;

    // Search upward from the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && req_i[IDX_W'(cand)]) begin
                found                 = 1'b1;
                grant_o[IDX_W'(cand)] = 1'b1;
                grant_idx_o           = IDX_W'(cand);
            end
        end
        ptr_d = (grant_idx_o == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_o + IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q <= '0;
        end else if (en_i) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/position_tx_scheduler.sv
// ----------------------------------------------------------------------------
// position_tx_scheduler : round-robin sequencer sharing one position serializer
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module position_tx_scheduler
    import pos_sched_pkg::*;
#(
    parameter  int NUM_REQ      = 4,
    parameter  int POS_W        = POS_W_DEFAULT,
    parameter  int ACK_TIMEOUT  = 8,
    parameter  int XFER_TIMEOUT = 4096,
    parameter  int MIN_GAP      = 4,
    localparam int CH_W         = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*POS_W-1:0] req_position,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [POS_W-1:0]         tx_position,
    output logic [CH_W-1:0]          tx_channel,
    output logic                     tx_start,
    input  logic                     tx_busy,
    output logic                     sched_busy,
    output logic                     timeout_err,
    output logic [FCNT_W-1:0]        frame_count
);

    localparam logic [TIMER_W-1:0] ACK_LAST  = TIMER_W'(ACK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] XFER_LAST = TIMER_W'(XFER_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'(MIN_GAP - 1);
    // With no gap configured the frame end returns straight to IDLE.
    localparam state_t END_STATE = (MIN_GAP == 0) ? IDLE : GAP;

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d, timer_inc;
    logic [POS_W-1:0]     pos_q, pos_d;
    logic [CH_W-1:0]      chan_q, chan_d;
    logic                 err_q, err_d;
    logic [FCNT_W-1:0]    fcnt_q, fcnt_d;
    logic [NUM_REQ-1:0]   grant;
    logic [CH_W-1:0]      grant_idx;
    logic                 arb_en;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req_valid),
        .en_i        (arb_en),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    always_comb begin
        timer_inc = (timer_q == '1) ? timer_q : timer_q + TIMER_W'(1);
        state_d   = state_q;
        timer_d   = timer_inc;
        pos_d     = pos_q;
        chan_d    = chan_q;
        err_d     = err_q;
        fcnt_d    = fcnt_q;
        arb_en    = 1'b0;
        tx_start  = 1'b0;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                req_ready = grant;
                timer_d   = '0;
                if (|grant) begin
                    arb_en  = 1'b1;
                    pos_d   = req_position[int'(grant_idx) * POS_W +: POS_W];
                    chan_d  = grant_idx;
                    state_d = START;
                end
            end
            START: begin
                tx_start = 1'b1;
                timer_d  = '0;
                state_d  = WAIT_ACK;
            end
            WAIT_ACK: begin
                // Busy takes priority over an ack timeout in the same cycle.
                if (tx_busy) begin
                    timer_d = '0;
                    state_d = XFER;
                end else if (timer_q == ACK_LAST) begin
                    timer_d = '0;
                    err_d   = 1'b1;
                    state_d = END_STATE;
                end
            end
            XFER: begin
                if (!tx_busy) begin
                    timer_d = '0;
                    fcnt_d  = fcnt_q + FCNT_W'(1);
                    state_d = END_STATE;
                end else if (timer_q == XFER_LAST) begin
                    timer_d = '0;
                    err_d   = 1'b1;
                    state_d = END_STATE;
                end
            end
            GAP: begin
                if (timer_q == GAP_LAST) begin
                    timer_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                timer_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            pos_q   <= '0;
            chan_q  <= '0;
            err_q   <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pos_q   <= pos_d;
            chan_q  <= chan_d;
            err_q   <= err_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign tx_position = pos_q;
    assign tx_channel  = chan_q;
    assign sched_busy  = (state_q != IDLE);
    assign timeout_err = err_q;
    assign frame_count = fcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_position_tx_scheduler.sv
// ----------------------------------------------------------------------------
// tb_position_tx_scheduler : scoreboard bench for position_tx_scheduler
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_position_tx_scheduler;

    localparam int NUM_REQ = 4;
    localparam int POS_W   = 10;
    localparam int B       = 40;
    localparam int MIN_GAP = 4;

    logic                     clk = 1'b0;
    logic                     reset = 1'b0;
    logic [NUM_REQ-1:0]       req_valid = '0;
    logic [NUM_REQ*POS_W-1:0] req_position = '0;
    logic [NUM_REQ-1:0]       req_ready;
    logic [POS_W-1:0]         tx_position;
    logic [1:0]               tx_channel;
    logic                     tx_start;
    logic                     tx_busy = 1'b0;
    logic                     sched_busy;
    logic                     timeout_err;
    logic [15:0]              frame_count;

    position_tx_scheduler #(
        .NUM_REQ      (NUM_REQ),
        .POS_W        (POS_W),
        .ACK_TIMEOUT  (8),
        .XFER_TIMEOUT (4096),
        .MIN_GAP      (MIN_GAP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_position (req_position),
        .req_ready    (req_ready),
        .tx_position  (tx_position),
        .tx_channel   (tx_channel),
        .tx_start     (tx_start),
        .tx_busy      (tx_busy),
        .sched_busy   (sched_busy),
        .timeout_err  (timeout_err),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [1:0]       ch;
        logic [POS_W-1:0] pos;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   n_starts    = 0;
    int   start_cyc[16];
    int   ser_mode    = 0;   // 0: busy for B cycles, 1: never busy, 2: stuck busy

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input int ch, input logic [POS_W-1:0] pos);
        exp_t e;
        e.ch  = 2'(ch);
        e.pos = pos;
        exp_q.push_back(e);
        req_position[ch*POS_W +: POS_W] = pos;
        req_valid[ch] = 1'b1;
    endtask

    task automatic do_reset();
        step();
        reset     = 1'b0;
        req_valid = '0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic wait_starts(input int target, input int budget);
        int k = 0;
        while (n_starts < target && k < budget) begin
            step();
            k++;
        end
        check("start_within_budget", 32'(n_starts >= target), 1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (sched_busy && k < budget) begin
            step();
            k++;
        end
        check("idle_within_budget", 32'(sched_busy), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},   req_ready,   0);
        check({tag, "_tx_start"},    tx_start,    0);
        check({tag, "_tx_position"}, tx_position, 0);
        check({tag, "_tx_channel"},  tx_channel,  0);
        check({tag, "_sched_busy"},  sched_busy,  0);
        check({tag, "_timeout_err"}, timeout_err, 0);
        check({tag, "_frame_count"}, frame_count, 0);
        check({tag, "_rr_ptr"},      dut.u_arb.ptr_q, 0);
    endtask

    // Monitor: every start pulse pops one expected frame from the scoreboard.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                check("start_single_cycle", prev, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_start", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_channel", tx_channel, e.ch);
                    check("tx_position", tx_position, e.pos);
                end
                if (n_starts < 16) start_cyc[n_starts] = cyc;
                n_starts++;
            end
            prev = tx_start;
        end
    end

    // Serializer model: busy rises the cycle after tx_start.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start) begin
                if (ser_mode == 0) begin
                    @(negedge clk);
                    tx_busy = 1'b1;
                    repeat (B) @(negedge clk);
                    tx_busy = 1'b0;
                end else if (ser_mode == 2) begin
                    @(negedge clk);
                    tx_busy = 1'b1;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got time limit, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        int n0;

        // Reset state while reset is held low
        step();
        step();
        check_reset_outputs("rst");
        reset = 1'b1;

        // Single request on channel 0
        ser_mode = 0;
        step();
        issue(0, 10'd1023);
        #1;
        check("t1_req_ready", req_ready, 4'b0001);
        step();
        req_valid = '0;
        check("t1_start_next_cycle", tx_start, 1);
        s = cyc;
        wait_idle(200);
        check("t1_idle_after_busy_fall_plus_gap", cyc - s, B + 6);
        check("t1_frame_count", frame_count, 1);
        check("t1_no_error", timeout_err, 0);

        // Round robin across all four channels
        do_reset();
        n0 = n_starts;
        issue(0, 10'd681);
        issue(1, 10'd1);
        issue(2, 10'd2);
        issue(3, 10'd3);
        begin
            exp_t e;
            e.ch = 2'd0; e.pos = 10'd681;
            exp_q.push_back(e);
        end
        wait_starts(n0 + 5, 400);
        req_valid = '0;
        check("t2_frame_period", start_cyc[n0+4] - start_cyc[n0+3], B + 3 + MIN_GAP);
        wait_idle(200);
        check("t2_frame_count", frame_count, 5);

        // Ack timeout: serializer never responds
        do_reset();
        ser_mode = 1;
        n0 = n_starts;
        issue(1, 10'd5);
        wait_starts(n0 + 1, 20);
        req_valid = '0;
        s = cyc;
        repeat (8) step();
        check("t3_err_clear_during_wait", timeout_err, 0);
        step();
        check("t3_err_set", timeout_err, 1);
        repeat (3) step();
        check("t3_gap_busy", sched_busy, 1);
        step();
        check("t3_idle_after_gap", sched_busy, 0);
        check("t3_frame_count", frame_count, 0);
        check("t3_cycles", cyc - s, 13);

        // Xfer timeout: busy stuck high
        do_reset();
        ser_mode = 2;
        n0 = n_starts;
        issue(3, 10'd77);
        wait_starts(n0 + 1, 20);
        req_valid = '0;
        repeat (4097) step();
        check("t4_err_clear_before_limit", timeout_err, 0);
        step();
        check("t4_err_set", timeout_err, 1);
        check("t4_frame_count", frame_count, 0);
        check("t4_position_held", tx_position, 77);
        check("t4_channel_held", tx_channel, 3);
        tx_busy  = 1'b0;
        ser_mode = 0;
        wait_idle(20);

        // Reset in the middle of a transfer
        do_reset();
        n0 = n_starts;
        issue(0, 10'd681);
        wait_starts(n0 + 1, 20);
        req_valid = '0;
        repeat (10) step();
        check("t5_in_xfer", sched_busy, 1);
        reset = 1'b0;
        step();
        check_reset_outputs("t5");
        reset = 1'b1;
        begin
            int k = 0;
            while (tx_busy && k < 100) begin
                step();
                k++;
            end
        end
        issue(2, 10'd1023);
        #1;
        check("t5_req_ready", req_ready, 4'b0100);
        wait_starts(n0 + 2, 20);
        req_valid = '0;
        wait_idle(200);
        check("t5_frame_count", frame_count, 1);

        // Frame counter wrap
        do_reset();
        step();
        force dut.fcnt_q = 16'hFFFF;
        step();
        release dut.fcnt_q;
        step();
        check("t6_preload", frame_count, 16'hFFFF);
        n0 = n_starts;
        issue(1, 10'd300);
        wait_starts(n0 + 1, 20);
        req_valid = '0;
        wait_idle(200);
        check("t6_wrap", frame_count, 0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/position_tx_scheduler.md
# position_tx_scheduler

Sequencer and round-robin arbiter that shares the single position serializer (`serial_output`, SCL/SDA) among several position sources. It accepts 10-bit position words from up to NUM_REQ requesters over valid/ready handshakes, issues one-shot start pulses to the serializer, and tracks the serializer's busy flag with timeouts. It enforces a minimum idle gap between frames and reports frame count and error status to the control logic.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- POS_W, 10: position word width.
- ACK_TIMEOUT, 8: maximum cycles from tx_start until tx_busy must rise.
- XFER_TIMEOUT, 4096: maximum cycles tx_busy may stay high.
- MIN_GAP, 4: idle cycles between frames; 0 means no gap.
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester valid.
- req_position  in  NUM_REQ*POS_W  packed positions; requester i occupies bits [i*POS_W +: POS_W].
- req_ready  out  NUM_REQ  one-hot grant; the transfer happens in the cycle where valid and ready are both high.
- tx_position  out  POS_W  word driven to the serializer's Position input.
- tx_channel  out  clog2(NUM_REQ)  index of the requester that owns the current frame.
- tx_start  out  1  one-cycle start pulse to the serializer.
- tx_busy  in  1  serializer busy flag.
- sched_busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky error flag; cleared only by reset.
- frame_count  out  16  count of completed frames; wraps at 65535 to 0.

## Operation
- States: IDLE, START, WAIT_ACK, XFER, GAP.
- **IDLE:** req_ready is combinational and exists only in IDLE. The grant goes to the first requester with valid high, searching from rr_ptr upward modulo NUM_REQ.
  - On a grant: latch req_position[g] into tx_position and g into tx_channel.
  - Set rr_ptr = (g+1) mod NUM_REQ.
  - Go to START.
- **START:** tx_start = 1 for exactly one cycle, then go to WAIT_ACK and clear the timer.
- **WAIT_ACK:**
  - If tx_busy = 1, go to XFER and clear the timer.
  - Else, if the timer reaches ACK_TIMEOUT-1, set timeout_err and go to GAP.
- **XFER:**
  - If tx_busy = 0, increment frame_count and go to GAP.
  - Else, if the timer reaches XFER_TIMEOUT-1, set timeout_err and go to GAP. The frame is not counted.
- **GAP:** count MIN_GAP cycles, then go to IDLE. If MIN_GAP = 0, go straight from XFER/WAIT_ACK to IDLE.
- tx_position and tx_channel hold their values from the grant until the next grant, including across timeouts.
- A requester that drops valid before it is granted loses nothing; it is simply not granted.
- The timer is shared by all states, is 13 bits wide, and saturates; it never wraps.

## Timing
- Reset values: req_ready 0, tx_start 0, tx_position 0, tx_channel 0, sched_busy 0, timeout_err 0, frame_count 0, rr_ptr 0, state IDLE.
- Grant to start: the grant happens in cycle n, so tx_start is high in cycle n+1.
- Earliest next grant after tx_busy falls: cycle +1+MIN_GAP.
- Back-to-back throughput with a serializer busy B cycles is one frame per B+3+MIN_GAP cycles, assuming tx_busy rises the cycle after tx_start.
- Simultaneous tx_busy=1 and ack timeout in the same cycle: busy wins (go to XFER).
- Simultaneous tx_busy=0 and xfer timeout in the same cycle: completion wins (count the frame, no error).
- Reset low in any state: all registers take reset values at that edge.
  - tx_start is low in the following cycle.
  - An in-flight frame is abandoned and not counted.

## Structure
- Shared package `pos_sched_pkg`:
  - state enum (IDLE/START/WAIT_ACK/XFER/GAP)
  - default POS_W = 10
  - timer width
  - frame counter width
- One sub-module, `rr_arbiter`: parameterised NUM_REQ, combinational one-hot grant from req vector plus pointer, with a registered pointer update on an enable.

## Test plan
- **Single request:** ch0 asserts valid with 1023; serializer model raises busy 1 cycle after start for 40 cycles.
  - Expect req_ready[0] the same cycle and tx_start one cycle later.
  - Expect tx_position=1023, tx_channel=0, frame_count=1, and the next grant ≥4 cycles after busy falls.
- **Round-robin:** all four channels hold valid with 681, 1, 2, 3.
  - Expect grants 0,1,2,3,0 in order, tx_position following each grant, and frame_count=5.
- **Ack timeout:** the serializer never raises busy.
  - Expect timeout_err set 8 cycles after tx_start, frame_count unchanged, and a return to IDLE after the gap.
- **Xfer timeout:** busy is stuck high.
  - Expect timeout_err after 4096 cycles in XFER and no frame counted.
- **Reset mid-transfer:** pull reset low during XFER with tx_position=681.
  - After the edge: all outputs 0, state IDLE, rr_ptr 0.
  - After release, a ch2 request for 1023 is granted normally.
- **Counter wrap:** preload 65535 frames (force or long run).
  - The next completion gives frame_count=0.
